sb_pattern_generator: RTL and testbench

// - TX-side counterpart of the sideband pattern detector. Drives 64-bit beats into the sideband serializer.
// - In RESET/SBINIT it sends the sideband clock pattern 64'hAAAA_AAAA_AAAA_AAAA (bit63=1, alternating).
// - After the local detector reports pattern lock, it sends EXTRA_ITER more iterations, then signals done.
// - In every other link state it is a pass-through from the message encoder to the serializer.

---
 rtl/sb_pkg.sv | 21 ++
 rtl/sb_gap_counter.sv | 33 +++
 rtl/sb_pattern_generator.sv | 164 ++++++++++++++++
 tb/tb_sb_pattern_generator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared sideband definitions: link-state codes, clock pattern word and the
// pattern FSM encoding used by both the generator and the detector.
package sb_pkg;

    localparam logic [2:0]  LS_RESET   = 3'd0;
    localparam logic [2:0]  LS_SBINIT  = 3'd1;
    localparam logic [63:0] SB_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_GAP   = 3'd2,
        ST_EXTRA = 3'd3,
        ST_DONE  = 3'd4
    } sb_state_e;

    function automatic logic is_pattern_state(input logic [2:0] link_state);
        return (link_state == LS_RESET) || (link_state == LS_SBINIT);
    endfunction

endpackage

// File: rtl/sb_gap_counter.sv
// Loadable saturating down-counter; o_tc is high while the count sits at zero.
module sb_gap_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == '0);

endmodule

// File: rtl/sb_pattern_generator.sv
// Sideband TX pattern generator: clock pattern during RESET/SBINIT, then a fixed
// number of extra iterations after lock; registered pass-through otherwise.
//   state | meaning
//   IDLE  | no pattern activity
//   SEND  | sending pattern, waiting for detector lock
//   GAP   | idle spacing after an accepted pattern beat
//   EXTRA | post-lock iterations being counted
//   DONE  | extra iterations complete
module sb_pattern_generator
    import sb_pkg::*;
#(
    parameter logic [63:0] PATTERN    = SB_PATTERN,
    parameter int unsigned EXTRA_ITER = 4,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_state,
    input  logic        i_start_pattern,
    input  logic        i_rx_pattern_detected,
    input  logic [63:0] i_msg_data,
    input  logic        i_msg_valid,
    output logic        o_msg_ready,
    output logic [63:0] o_ser_data,
    output logic        o_ser_valid,
    input  logic        i_ser_ready,
    output logic        o_pattern_done,
    output logic        o_busy
);

    localparam bit         HAS_GAP    = (GAP_CYCLES != 0);
    localparam logic [7:0] GAP_LOAD   = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [3:0] EXTRA_LAST = 4'(EXTRA_ITER);

    sb_state_e   state_q, state_d;
    logic        ret_extra_q, ret_extra_d;
    logic        det_q, det_d;
    logic [3:0]  iter_q, iter_d, iter_inc;
    logic [2:0]  ls_q;
    logic        valid_q, valid_d;
    logic [63:0] data_q, data_d;
    logic        done_q, done_d;
    logic        gap_load, gap_tc;
    logic        bypass, accept;

    sb_gap_counter #(.W(8)) u_gap (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (gap_load),
        .i_load_val (GAP_LOAD),
        .o_tc       (gap_tc)
    );

    assign bypass   = !is_pattern_state(i_state);
    assign accept   = valid_q & i_ser_ready;
    assign iter_inc = (iter_q != 4'hF) ? iter_q + 4'd1 : iter_q;

    always_comb begin
        state_d     = state_q;
        ret_extra_d = ret_extra_q;
        det_d       = det_q;
        iter_d      = iter_q;
        done_d      = 1'b0;
        gap_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start_pattern) begin
                    state_d     = ST_SEND;
                    det_d       = 1'b0;
                    iter_d      = 4'd0;
                    ret_extra_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (i_rx_pattern_detected) begin
                    det_d  = 1'b1;
                    iter_d = 4'd0;
                end
                // The beat accepted here is never an extra iteration, even with a same-cycle detect.
                if (accept) begin
                    if (HAS_GAP) begin
                        state_d     = ST_GAP;
                        gap_load    = 1'b1;
                        ret_extra_d = det_d;
                    end else begin
                        state_d = det_d ? ST_EXTRA : ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                if (i_rx_pattern_detected && !ret_extra_q) begin
                    det_d  = 1'b1;
                    iter_d = 4'd0;
                end
                if (gap_tc) begin
                    state_d = (ret_extra_q || det_d) ? ST_EXTRA : ST_SEND;
                end
            end
            ST_EXTRA: begin
                if (accept) begin
                    iter_d = iter_inc;
                    if (iter_inc == EXTRA_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (HAS_GAP) begin
                        state_d     = ST_GAP;
                        gap_load    = 1'b1;
                        ret_extra_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (i_start_pattern || (i_state != ls_q)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bypass) begin
            state_d     = ST_IDLE;
            det_d       = 1'b0;
            iter_d      = 4'd0;
            ret_extra_d = 1'b0;
            done_d      = 1'b0;
            gap_load    = 1'b0;
            valid_d     = i_msg_valid;
            data_d      = i_msg_data;
        end else begin
            valid_d = (state_d == ST_SEND) || (state_d == ST_EXTRA);
            data_d  = valid_d ? PATTERN : 64'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            ret_extra_q <= 1'b0;
            det_q       <= 1'b0;
            iter_q      <= 4'd0;
            ls_q        <= LS_RESET;
            valid_q     <= 1'b0;
            data_q      <= 64'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_extra_q <= ret_extra_d;
            det_q       <= det_d;
            iter_q      <= iter_d;
            ls_q        <= i_state;
            valid_q     <= valid_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    assign o_ser_valid    = valid_q;
    assign o_ser_data     = data_q;
    assign o_pattern_done = done_q;
    assign o_msg_ready    = bypass ? i_ser_ready : 1'b0;
    assign o_busy         = (state_q == ST_SEND) || (state_q == ST_GAP) || (state_q == ST_EXTRA);

endmodule

// File: tb/tb_sb_pattern_generator.sv
// Directed bench for sb_pattern_generator: default instance plus a GAP_CYCLES=3 instance.
module tb_sb_pattern_generator;

    localparam logic [63:0] PAT  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WORD = 64'h1234_5678_9ABC_DEF0;

    logic        clk;
    logic        rst_n;
    logic [2:0]  lstate;
    logic        start;
    logic        det;
    logic [63:0] msg_data;
    logic        msg_valid;
    logic        ser_ready;

    logic        a_msg_ready, a_ser_valid, a_done, a_busy;
    logic [63:0] a_ser_data;
    logic        g_msg_ready, g_ser_valid, g_done, g_busy;
    logic [63:0] g_ser_data;

    int n_checks = 0;
    int n_fail   = 0;

    sb_pattern_generator u_dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_state               (lstate),
        .i_start_pattern       (start),
        .i_rx_pattern_detected (det),
        .i_msg_data            (msg_data),
        .i_msg_valid           (msg_valid),
        .o_msg_ready           (a_msg_ready),
        .o_ser_data            (a_ser_data),
        .o_ser_valid           (a_ser_valid),
        .i_ser_ready           (ser_ready),
        .o_pattern_done        (a_done),
        .o_busy                (a_busy)
    );

    sb_pattern_generator #(.GAP_CYCLES(3)) u_gap_dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_state               (lstate),
        .i_start_pattern       (start),
        .i_rx_pattern_detected (det),
        .i_msg_data            (msg_data),
        .i_msg_valid           (msg_valid),
        .o_msg_ready           (g_msg_ready),
        .o_ser_data            (g_ser_data),
        .o_ser_valid           (g_ser_valid),
        .i_ser_ready           (ser_ready),
        .o_pattern_done        (g_done),
        .o_busy                (g_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; lstate = 3'd1; start = 1'b0; det = 1'b0;
        msg_data = 64'd0; msg_valid = 1'b0; ser_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lstate    = 3'(i % 2);
            start     = (i % 2 == 0);
            det       = (i % 2 == 1);
            msg_valid = 1'b1;
            msg_data  = WORD ^ 64'(i);
            ser_ready = (i % 2 == 0);
            tick();
            n_checks++; if (a_ser_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, a_ser_valid); end
            n_checks++; if (a_ser_data !== 64'd0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h expected 0", i, a_ser_data); end
            n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", i, a_done); end
            n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, a_busy); end
            n_checks++; if (a_msg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_msg_ready[%0d]: got %b expected 0", i, a_msg_ready); end
            n_checks++; if (g_ser_valid !== 1'b0 || g_busy !== 1'b0) begin n_fail++; $display("FAIL reset_gap_dut[%0d]: got valid=%b busy=%b expected 0/0", i, g_ser_valid, g_busy); end
        end
        rst_n = 1'b1; start = 1'b0; det = 1'b0; msg_valid = 1'b0; ser_ready = 1'b1;
        tick();
        n_checks++; if (a_busy !== 1'b0 || a_ser_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got busy=%b valid=%b expected 0/0", a_busy, a_ser_valid); end
    endtask

    task automatic test_basic();
        int  n_acc, done_cnt;
        logic prev_acc, done_ok;
        do_reset();
        lstate = 3'd1; ser_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (a_ser_valid !== 1'b1 || a_ser_data !== PAT) begin n_fail++; $display("FAIL basic_send[%0d]: got valid=%b data=%h expected 1/%h", i, a_ser_valid, a_ser_data, PAT); end
            n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy[%0d]: got %b expected 1", i, a_busy); end
            tick();
        end
        det = 1'b1; tick(); det = 1'b0;
        n_acc = 0; done_cnt = 0; done_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (a_ser_valid === 1'b1) begin
                n_checks++; if (a_ser_data !== PAT) begin n_fail++; $display("FAIL basic_extra_data[%0d]: got %h expected %h", i, a_ser_data, PAT); end
            end
            prev_acc = a_ser_valid & ser_ready;
            if (prev_acc) n_acc++;
            tick();
            if (a_done === 1'b1) begin
                done_cnt++;
                done_ok = prev_acc && (n_acc == 4);
            end
        end
        n_checks++; if (n_acc !== 4) begin n_fail++; $display("FAIL basic_extra_beats: got %0d expected 4", n_acc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (done_ok !== 1'b1) begin n_fail++; $display("FAIL basic_done_timing: got %b expected 1", done_ok); end
        n_checks++; if (a_busy !== 1'b0 || a_ser_valid !== 1'b0) begin n_fail++; $display("FAIL basic_after_done: got busy=%b valid=%b expected 0/0", a_busy, a_ser_valid); end
    endtask

    task automatic test_backpressure();
        int          n_acc, done_cnt;
        logic        prev_acc, done_ok, prev_valid, prev_ready;
        logic [63:0] prev_data;
        do_reset();
        lstate = 3'd1; ser_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        det = 1'b1; tick(); det = 1'b0;
        n_acc = 0; done_cnt = 0; done_ok = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b1; prev_data = 64'd0;
        for (int i = 0; i < 12; i++) begin
            ser_ready = (i % 2 == 0);
            if (prev_valid && !prev_ready) begin
                n_checks++; if (a_ser_valid !== 1'b1 || a_ser_data !== prev_data) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1/%h", i, a_ser_valid, a_ser_data, prev_data); end
            end
            if (a_ser_valid === 1'b1) begin
                n_checks++; if (a_ser_data !== PAT) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, a_ser_data, PAT); end
            end
            prev_valid = a_ser_valid; prev_ready = ser_ready; prev_data = a_ser_data;
            prev_acc = a_ser_valid & ser_ready;
            if (prev_acc) n_acc++;
            tick();
            if (a_done === 1'b1) begin
                done_cnt++;
                done_ok = prev_acc && (n_acc == 4);
            end
        end
        ser_ready = 1'b1;
        n_checks++; if (n_acc !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 4", n_acc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (done_ok !== 1'b1) begin n_fail++; $display("FAIL bp_done_timing: got %b expected 1", done_ok); end
    endtask

    task automatic test_gap();
        logic exp_v;
        do_reset();
        lstate = 3'd0; ser_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            exp_v = (i % 4 == 0) && (i <= 32);
            n_checks++; if (g_ser_valid !== exp_v) begin n_fail++; $display("FAIL gap_valid[%0d]: got %b expected %b", i, g_ser_valid, exp_v); end
            n_checks++; if (g_busy !== (i <= 32)) begin n_fail++; $display("FAIL gap_busy[%0d]: got %b expected %b", i, g_busy, (i <= 32)); end
            n_checks++; if (g_done !== (i == 33)) begin n_fail++; $display("FAIL gap_done[%0d]: got %b expected %b", i, g_done, (i == 33)); end
            if (exp_v) begin
                n_checks++; if (g_ser_data !== PAT) begin n_fail++; $display("FAIL gap_data[%0d]: got %h expected %h", i, g_ser_data, PAT); end
            end
            det = (i == 17);
            tick();
        end
        det = 1'b0;
    endtask

    task automatic test_bypass();
        do_reset();
        lstate = 3'd3; msg_data = WORD; msg_valid = 1'b1; ser_ready = 1'b0;
        #1;
        n_checks++; if (a_msg_ready !== 1'b0) begin n_fail++; $display("FAIL byp_ready_lo: got %b expected 0", a_msg_ready); end
        tick();
        n_checks++; if (a_ser_valid !== 1'b1 || a_ser_data !== WORD) begin n_fail++; $display("FAIL byp_word: got valid=%b data=%h expected 1/%h", a_ser_valid, a_ser_data, WORD); end
        ser_ready = 1'b1;
        #1;
        n_checks++; if (a_msg_ready !== 1'b1) begin n_fail++; $display("FAIL byp_ready_hi: got %b expected 1", a_msg_ready); end
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (a_ser_data !== WORD || a_busy !== 1'b0) begin n_fail++; $display("FAIL byp_no_pattern: got data=%h busy=%b expected %h/0", a_ser_data, a_busy, WORD); end
        msg_valid = 1'b0; tick();
        n_checks++; if (a_ser_valid !== 1'b0) begin n_fail++; $display("FAIL byp_valid_drop: got %b expected 0", a_ser_valid); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL byp_done: got %b expected 0", a_done); end
    endtask

    task automatic test_midop();
        int done_cnt;
        do_reset();
        lstate = 3'd1; ser_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        det = 1'b1; tick(); det = 1'b0;
        tick();
        n_checks++; if (a_busy !== 1'b1 || a_ser_valid !== 1'b1) begin n_fail++; $display("FAIL mid_in_extra: got busy=%b valid=%b expected 1/1", a_busy, a_ser_valid); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_checks++; if (a_busy !== 1'b0 || a_ser_valid !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got busy=%b valid=%b done=%b expected 0/0/0", a_busy, a_ser_valid, a_done); end
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (a_ser_valid !== 1'b1 || a_ser_data !== PAT) begin n_fail++; $display("FAIL mid_restart: got valid=%b data=%h expected 1/%h", a_ser_valid, a_ser_data, PAT); end
        lstate = 3'd2; msg_valid = 1'b0; msg_data = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        n_checks++; if (a_ser_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_bypass: got valid=%b busy=%b expected 0/0", a_ser_valid, a_busy); end
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            det = (i == 1);
            tick();
            if (a_done === 1'b1) done_cnt++;
        end
        det = 1'b0;
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt); end
        lstate = 3'd1; tick();
        n_checks++; if (a_busy !== 1'b0 || a_ser_valid !== 1'b0) begin n_fail++; $display("FAIL mid_back_idle: got busy=%b valid=%b expected 0/0", a_busy, a_ser_valid); end
    endtask

    initial begin
        rst_n = 1'b0; lstate = 3'd0; start = 1'b0; det = 1'b0;
        msg_data = 64'd0; msg_valid = 1'b0; ser_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_bypass();
        test_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
